// File: rtl/mem_stage_param.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_param
//  Description : Pipeline memory stage driving an asynchronous SRAM. A word
//                access is split into BEATS narrow SRAM beats, each held for
//                WAIT_CYCLES+1 cycles. The pipeline is frozen (ready=0) while
//                the access runs. Out-of-window requests are rejected.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_param #(
  parameter int WORD_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               writeBackEn_EXE_Reg,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [WORD_W-1:0]  address,
  input  logic [WORD_W-1:0]  data,
  inout  wire  [SRAM_DW-1:0] sramData,
  output logic [SRAM_AW-1:0] sramAddress,
  output logic [4:0]         sramCtrl,
  output logic [WORD_W-1:0]  memResult,
  output logic               writeBackEn,
  output logic               ready,
  output logic               addrError
);

  localparam int c_BEATS      = WORD_W / SRAM_DW;
  localparam int c_BYTE_SHIFT = $clog2(WORD_W / 8);
  localparam int c_BEAT_W     = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

  // Number of pipeline words that fit in the SRAM window.
  localparam logic [63:0] c_WORD_LIMIT = (64'd1 << SRAM_AW) / 64'(c_BEATS);

  localparam logic [WORD_W-1:0]   c_BASE      = WORD_W'(BASE_ADDR);
  localparam logic [3:0]          c_WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(c_BEATS - 1);

  // Control bus order: {WE_N, UB_N, LB_N, CE_N, OE_N}
  localparam logic [4:0] c_CTRL_IDLE  = 5'b11111;
  localparam logic [4:0] c_CTRL_WRITE = 5'b00001;
  localparam logic [4:0] c_CTRL_READ  = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_BEAT_W-1:0]  r_beat;
  logic [3:0]           r_wait;
  logic                 r_write;
  logic                 r_drive;
  logic [WORD_W-1:0]    r_data;
  logic [WORD_W-1:0]    r_result;
  logic [SRAM_AW-1:0]   r_addr;
  logic [4:0]           r_ctrl;

  logic                 w_req;
  logic                 w_idle;
  logic                 w_below;
  logic                 w_over;
  logic                 w_addr_bad;
  logic                 w_start;
  logic [WORD_W-1:0]    w_offset;
  logic [WORD_W-1:0]    w_word_idx;
  logic [SRAM_AW-1:0]   w_sram_base;
  logic [SRAM_DW-1:0]   w_wslice;

  // Request decode and SRAM window check (address arithmetic only).
  assign w_req       = memRead | memWrite;
  assign w_idle      = (r_state == S_IDLE);
  assign w_below     = (address < c_BASE);
  assign w_offset    = address - c_BASE;
  assign w_word_idx  = w_offset >> c_BYTE_SHIFT;
  assign w_over      = (64'(w_word_idx) >= c_WORD_LIMIT);
  assign w_addr_bad  = w_below | w_over;
  assign w_start     = w_idle & w_req & ~w_addr_bad;
  assign w_sram_base = SRAM_AW'(w_word_idx) * SRAM_AW'(c_BEATS);

  // Select the store-data slice for the current beat, low part first.
  always_comb begin
    w_wslice = '0;
    for (int b = 0; b < c_BEATS; b++) begin
      if (r_beat == c_BEAT_W'(b)) begin
        w_wslice = r_data[b*SRAM_DW +: SRAM_DW];
      end
    end
  end

  // Beat sequencer: latch request in IDLE, step wait/beat counters in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_wait   <= '0;
      r_write  <= 1'b0;
      r_drive  <= 1'b0;
      r_data   <= '0;
      r_result <= '0;
      r_addr   <= '0;
      r_ctrl   <= c_CTRL_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            // A simultaneous read and write is handled as a write.
            r_state <= S_ACCESS;
            r_beat  <= '0;
            r_wait  <= '0;
            r_write <= memWrite;
            r_drive <= memWrite;
            r_data  <= data;
            r_addr  <= w_sram_base;
            r_ctrl  <= memWrite ? c_CTRL_WRITE : c_CTRL_READ;
          end
        end
        S_ACCESS: begin
          if (r_wait == c_WAIT_LAST) begin
            // Last cycle of the beat: the SRAM output has settled.
            if (!r_write) begin
              for (int b = 0; b < c_BEATS; b++) begin
                if (r_beat == c_BEAT_W'(b)) begin
                  r_result[b*SRAM_DW +: SRAM_DW] <= sramData;
                end
              end
            end
            r_wait <= '0;
            if (r_beat == c_BEAT_LAST) begin
              r_state <= S_DONE;
              r_beat  <= '0;
              r_drive <= 1'b0;
              r_ctrl  <= c_CTRL_IDLE;
            end else begin
              r_beat <= r_beat + c_BEAT_W'(1);
              r_addr <= r_addr + SRAM_AW'(1);
            end
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        // Always pass through IDLE so a held request is not re-run here.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sramData    = r_drive ? w_wslice : {SRAM_DW{1'bz}};
  assign sramAddress = r_addr;
  assign sramCtrl    = r_ctrl;
  assign memResult   = r_result;
  assign ready       = (w_idle & ~w_start) | (r_state == S_DONE);
  assign writeBackEn = ready & writeBackEn_EXE_Reg;
  assign addrError   = w_idle & w_req & w_addr_bad;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_param
//  Description : Self-checking bench for mem_stage_param with an SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_param;

  localparam int WORD_W   = 32;
  localparam int SRAM_DW  = 16;
  localparam int SRAM_AW  = 18;
  localparam int WAIT_CYC = 2;
  localparam int BASE     = 1024;
  localparam int BEATS    = WORD_W / SRAM_DW;
  localparam int DONE_CYC = BEATS * (WAIT_CYC + 1) + 1;
  localparam int WORD_LIM = (1 << SRAM_AW) / BEATS;
  localparam logic [4:0] CTRL_IDLE = 5'b11111;
  localparam logic [4:0] CTRL_WR   = 5'b00001;
  localparam logic [4:0] CTRL_RD   = 5'b10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        wbe_exe, memRead, memWrite;
  logic [31:0] address, data;
  wire  [15:0] sramData;
  logic [17:0] sramAddress;
  logic [4:0]  sramCtrl;
  logic [31:0] memResult;
  logic        writeBackEn, ready, addrError;

  mem_stage_param u_dut (
    .clk(clk), .rst(rst), .writeBackEn_EXE_Reg(wbe_exe), .memRead(memRead),
    .memWrite(memWrite), .address(address), .data(data), .sramData(sramData),
    .sramAddress(sramAddress), .sramCtrl(sramCtrl), .memResult(memResult),
    .writeBackEn(writeBackEn), .ready(ready), .addrError(addrError)
  );

  // Zero-wait-state instance
  logic        wbe_z, memRead_z, memWrite_z;
  logic [31:0] address_z, data_z;
  wire  [15:0] sramData_z;
  logic [17:0] sramAddress_z;
  logic [4:0]  sramCtrl_z;
  logic [31:0] memResult_z;
  logic        writeBackEn_z, ready_z, addrError_z;

  mem_stage_param #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .writeBackEn_EXE_Reg(wbe_z), .memRead(memRead_z),
    .memWrite(memWrite_z), .address(address_z), .data(data_z), .sramData(sramData_z),
    .sramAddress(sramAddress_z), .sramCtrl(sramCtrl_z), .memResult(memResult_z),
    .writeBackEn(writeBackEn_z), .ready(ready_z), .addrError(addrError_z)
  );

  // SRAM model for the main instance; the probe driver shows a released bus.
  logic [15:0] sram_mem [0:(1<<SRAM_AW)-1] = '{default: 16'h0};
  logic        probe_en;
  logic [15:0] probe_val;
  wire         w_rd_mode = !sramCtrl[1] && !sramCtrl[0] && sramCtrl[4];
  wire         w_tb_en   = probe_en || w_rd_mode;
  wire  [15:0] w_tb_val  = probe_en ? probe_val : sram_mem[sramAddress];
  assign sramData = w_tb_en ? w_tb_val : 16'bz;

  always @(posedge clk) begin
    if (!sramCtrl[4] && !sramCtrl[1]) sram_mem[sramAddress] <= sramData;
  end

  // Zero-wait instance SRAM returns a pattern derived from the address.
  wire w_z_rd = !sramCtrl_z[1] && !sramCtrl_z[0] && sramCtrl_z[4];
  assign sramData_z = w_z_rd ? (16'(sramAddress_z) ^ 16'h5A5A) : 16'bz;

  // Reference memory contents and last loaded word.
  logic [15:0] ref_mem [int];
  logic [31:0] model_result;
  int unsigned n_vec, n_err;

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  // Per-cycle observation trace filled by run_access.
  logic [4:0]  obs_ctrl   [0:31];
  logic [17:0] obs_addr   [0:31];
  logic [15:0] obs_bus    [0:31];
  logic [15:0] obs_probe  [0:31];
  logic        obs_probed [0:31];
  logic [31:0] obs_res    [0:31];
  logic        obs_ready  [0:31];
  logic        obs_wb     [0:31];
  logic        obs_aerr   [0:31];

  // Applies a request at cycle 0 and records outputs at each negedge.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic wbe, input int ncyc,
                            input logic hold);
    memRead = rd; memWrite = wr; address = a; data = d; wbe_exe = wbe;
    for (int c = 0; c < ncyc; c++) begin
      probe_en  = (sramCtrl == CTRL_IDLE);
      probe_val = 16'($urandom);
      @(negedge clk);
      obs_ctrl[c] = sramCtrl;   obs_addr[c] = sramAddress; obs_bus[c] = sramData;
      obs_probe[c] = probe_val; obs_probed[c] = probe_en;  obs_res[c] = memResult;
      obs_ready[c] = ready;     obs_wb[c] = writeBackEn;   obs_aerr[c] = addrError;
      @(posedge clk); #1;
      probe_en = 1'b0;
      if (c == 0 && !hold) begin
        memRead = 1'b0; memWrite = 1'b0; address = $urandom; data = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    probe_en = 1'b1; probe_val = 16'h3C96; wbe_exe = 1'b1;
    @(negedge clk);
    n_vec++; if (sramCtrl !== CTRL_IDLE) begin n_err++; $display("FAIL rst_ctrl got=%b exp=%b", sramCtrl, CTRL_IDLE); end
    n_vec++; if (sramAddress !== 18'd0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", sramAddress); end
    n_vec++; if (memResult !== 32'd0) begin n_err++; $display("FAIL rst_result got=%h exp=0", memResult); end
    n_vec++; if (ready !== 1'b1 || writeBackEn !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b/%b exp=1/1", ready, writeBackEn); end
    n_vec++; if (sramData !== 16'h3C96) begin n_err++; $display("FAIL rst_bus_z got=%h exp=%h", sramData, 16'h3C96); end
    probe_en = 1'b0;
  endtask

  task automatic test_write_deadbeef();
    logic [4:0] ec;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b1, DONE_CYC + 1, 1'b0);
    for (int c = 0; c <= DONE_CYC; c++) begin
      ec = (c == 0 || c == 7) ? CTRL_IDLE : CTRL_WR;
      n_vec++; if (obs_ctrl[c] !== ec) begin n_err++; $display("FAIL wr_ctrl cyc=%0d got=%b exp=%b", c, obs_ctrl[c], ec); end
      if (c >= 1 && c <= 6) begin
        n_vec++; if (obs_addr[c] !== ((c <= 3) ? 18'd0 : 18'd1)) begin n_err++; $display("FAIL wr_addr cyc=%0d got=%h", c, obs_addr[c]); end
        n_vec++; if (obs_bus[c] !== ((c <= 3) ? 16'hBEEF : 16'hDEAD)) begin n_err++; $display("FAIL wr_bus cyc=%0d got=%h", c, obs_bus[c]); end
      end else begin
        n_vec++; if (!obs_probed[c] || obs_bus[c] !== obs_probe[c]) begin n_err++; $display("FAIL wr_bus_z cyc=%0d got=%h exp=%h", c, obs_bus[c], obs_probe[c]); end
      end
      n_vec++; if (obs_ready[c] !== (c == 7)) begin n_err++; $display("FAIL wr_ready cyc=%0d got=%b exp=%b", c, obs_ready[c], c == 7); end
      n_vec++; if (obs_res[c] !== model_result) begin n_err++; $display("FAIL wr_result_hold cyc=%0d got=%h exp=%h", c, obs_res[c], model_result); end
    end
    ref_mem[0] = 16'hBEEF; ref_mem[1] = 16'hDEAD;
  endtask

  task automatic test_read_back();
    run_access(1'b1, 1'b0, 32'd1024, $urandom, 1'b1, DONE_CYC + 1, 1'b0);
    for (int c = 0; c <= DONE_CYC; c++) begin
      n_vec++; if (obs_wb[c] !== (c == 7)) begin n_err++; $display("FAIL rd_wb cyc=%0d got=%b exp=%b", c, obs_wb[c], c == 7); end
      if (c >= 1 && c <= 6) begin
        n_vec++; if (obs_ctrl[c] !== CTRL_RD) begin n_err++; $display("FAIL rd_ctrl cyc=%0d got=%b exp=%b", c, obs_ctrl[c], CTRL_RD); end
      end
    end
    n_vec++; if (obs_res[7] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_result got=%h exp=deadbeef", obs_res[7]); end
    model_result = 32'hDEADBEEF;
  endtask

  task automatic test_wait0();
    logic [31:0] exp_res;
    exp_res = {16'd5 ^ 16'h5A5A, 16'd4 ^ 16'h5A5A};
    wbe_z = 1'b1; memRead_z = 1'b1; address_z = 32'd1032;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      n_vec++; if (ready_z !== (c >= 3)) begin n_err++; $display("FAIL w0_ready cyc=%0d got=%b exp=%b", c, ready_z, c >= 3); end
      n_vec++; if (sramCtrl_z !== ((c == 1 || c == 2) ? CTRL_RD : CTRL_IDLE)) begin n_err++; $display("FAIL w0_ctrl cyc=%0d got=%b", c, sramCtrl_z); end
      if (c == 1 || c == 2) begin
        n_vec++; if (sramAddress_z !== 18'(c + 3)) begin n_err++; $display("FAIL w0_addr cyc=%0d got=%h exp=%h", c, sramAddress_z, c + 3); end
      end
      if (c == 3) begin
        n_vec++; if (memResult_z !== exp_res) begin n_err++; $display("FAIL w0_result got=%h exp=%h", memResult_z, exp_res); end
        n_vec++; if (writeBackEn_z !== 1'b1) begin n_err++; $display("FAIL w0_wb got=%b exp=1", writeBackEn_z); end
      end
      @(posedge clk); #1;
      memRead_z = 1'b0;
    end
  endtask

  task automatic test_addr_window();
    logic [31:0] d;
    // Below the window, then the first word past the top of the window.
    for (int k = 0; k < 2; k++) begin
      run_access(k == 0, k == 1, (k == 0) ? 32'd1020 : 32'(BASE + WORD_LIM * 4), $urandom, 1'b1, 4, 1'b1);
      for (int c = 0; c < 4; c++) begin
        n_vec++; if (obs_aerr[c] !== 1'b1 || obs_ready[c] !== 1'b1 || obs_wb[c] !== 1'b1) begin
          n_err++; $display("FAIL aerr_flags k=%0d cyc=%0d got=%b%b%b exp=111", k, c, obs_aerr[c], obs_ready[c], obs_wb[c]); end
        n_vec++; if (obs_ctrl[c] !== CTRL_IDLE) begin n_err++; $display("FAIL aerr_ctrl k=%0d cyc=%0d got=%b", k, c, obs_ctrl[c]); end
        n_vec++; if (!obs_probed[c] || obs_bus[c] !== obs_probe[c]) begin n_err++; $display("FAIL aerr_bus_z k=%0d cyc=%0d got=%h exp=%h", k, c, obs_bus[c], obs_probe[c]); end
      end
      memRead = 1'b0; memWrite = 1'b0;
    end
    // Last word inside the window.
    d = $urandom;
    run_access(1'b0, 1'b1, 32'(BASE + (WORD_LIM - 1) * 4), d, 1'b0, DONE_CYC + 1, 1'b0);
    n_vec++; if (obs_aerr[0] !== 1'b0) begin n_err++; $display("FAIL top_aerr got=%b exp=0", obs_aerr[0]); end
    n_vec++; if (obs_ctrl[1] !== CTRL_WR || obs_addr[1] !== 18'h3FFFE) begin n_err++; $display("FAIL top_beat0 got=%b/%h exp=%b/3fffe", obs_ctrl[1], obs_addr[1], CTRL_WR); end
    n_vec++; if (obs_addr[4] !== 18'h3FFFF || obs_bus[4] !== d[31:16]) begin n_err++; $display("FAIL top_beat1 got=%h/%h exp=3ffff/%h", obs_addr[4], obs_bus[4], d[31:16]); end
    ref_mem[(WORD_LIM - 1) * 2] = d[15:0]; ref_mem[(WORD_LIM - 1) * 2 + 1] = d[31:16];
  endtask

  task automatic test_hold_request();
    int p;
    logic [31:0] exp_res;
    exp_res = {ref_rd(1), ref_rd(0)};
    run_access(1'b1, 1'b0, 32'd1024, $urandom, 1'b1, 2 * (DONE_CYC + 1), 1'b1);
    memRead = 1'b0;
    for (int c = 0; c < 2 * (DONE_CYC + 1); c++) begin
      p = c % (DONE_CYC + 1);
      n_vec++; if (obs_ready[c] !== (p == DONE_CYC)) begin n_err++; $display("FAIL hold_ready cyc=%0d got=%b exp=%b", c, obs_ready[c], p == DONE_CYC); end
      n_vec++; if (obs_ctrl[c] !== ((p == 0 || p == DONE_CYC) ? CTRL_IDLE : CTRL_RD)) begin n_err++; $display("FAIL hold_ctrl cyc=%0d got=%b", c, obs_ctrl[c]); end
    end
    n_vec++; if (obs_res[15] !== exp_res) begin n_err++; $display("FAIL hold_result got=%h exp=%h", obs_res[15], exp_res); end
    model_result = exp_res;
  endtask

  task automatic test_random_rw();
    int idx, beat;
    logic [1:0] mode;
    logic rd, wr, wbe, idle;
    logic [31:0] d, exp_res;
    logic [4:0] ec;
    for (int t = 0; t < 24; t++) begin
      idx = $urandom_range(0, 255); mode = 2'($urandom_range(1, 3));
      rd = mode[0]; wr = mode[1]; wbe = 1'($urandom); d = $urandom;
      exp_res = model_result;
      if (!wr) for (int b = 0; b < BEATS; b++) exp_res[b*SRAM_DW +: SRAM_DW] = ref_rd(idx * BEATS + b);
      run_access(rd, wr, 32'(BASE + idx * 4 + $urandom_range(0, 3)), d, wbe, DONE_CYC + 1, 1'b0);
      for (int c = 0; c <= DONE_CYC; c++) begin
        idle = (c == 0) || (c == DONE_CYC);
        beat = (c == 0) ? 0 : (c - 1) / (WAIT_CYC + 1);
        ec = idle ? CTRL_IDLE : (wr ? CTRL_WR : CTRL_RD);
        n_vec++; if (obs_ctrl[c] !== ec) begin n_err++; $display("FAIL rnd_ctrl t=%0d cyc=%0d got=%b exp=%b", t, c, obs_ctrl[c], ec); end
        if (!idle) begin
          n_vec++; if (obs_addr[c] !== 18'(idx * BEATS + beat)) begin n_err++; $display("FAIL rnd_addr t=%0d cyc=%0d got=%h exp=%h", t, c, obs_addr[c], idx * BEATS + beat); end
          if (wr) begin
            n_vec++; if (obs_bus[c] !== 16'(d >> (SRAM_DW * beat))) begin n_err++; $display("FAIL rnd_bus t=%0d cyc=%0d got=%h exp=%h", t, c, obs_bus[c], 16'(d >> (SRAM_DW * beat))); end
          end
        end else begin
          n_vec++; if (!obs_probed[c] || obs_bus[c] !== obs_probe[c]) begin n_err++; $display("FAIL rnd_bus_z t=%0d cyc=%0d got=%h exp=%h", t, c, obs_bus[c], obs_probe[c]); end
        end
        n_vec++; if (obs_ready[c] !== (c == DONE_CYC) || obs_wb[c] !== ((c == DONE_CYC) && wbe)) begin
          n_err++; $display("FAIL rnd_ready_wb t=%0d cyc=%0d got=%b/%b exp=%b/%b", t, c, obs_ready[c], obs_wb[c], c == DONE_CYC, (c == DONE_CYC) && wbe); end
        if (wr || c == DONE_CYC) begin
          n_vec++; if (obs_res[c] !== exp_res) begin n_err++; $display("FAIL rnd_result t=%0d cyc=%0d got=%h exp=%h", t, c, obs_res[c], exp_res); end
        end
      end
      if (wr) for (int b = 0; b < BEATS; b++) ref_mem[idx * BEATS + b] = 16'(d >> (SRAM_DW * b));
      model_result = exp_res;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_res;
    memWrite = 1'b1; address = 32'(BASE + 300 * 4); data = $urandom;
    @(posedge clk); #1;
    memWrite = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    // Now in cycle 5 (second beat): assert reset away from any clock edge.
    #2; rst = 1'b1; probe_en = 1'b1; probe_val = 16'h6A91;
    #1;
    n_vec++; if (sramCtrl !== CTRL_IDLE) begin n_err++; $display("FAIL mid_ctrl got=%b exp=%b", sramCtrl, CTRL_IDLE); end
    n_vec++; if (sramData !== 16'h6A91) begin n_err++; $display("FAIL mid_bus_z got=%h exp=6a91", sramData); end
    n_vec++; if (memResult !== 32'd0 || ready !== 1'b1 || sramAddress !== 18'd0) begin
      n_err++; $display("FAIL mid_state got=%h/%b/%h exp=0/1/0", memResult, ready, sramAddress); end
    @(posedge clk); #1;
    rst = 1'b0; probe_en = 1'b0; model_result = 32'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++; if (sramCtrl !== CTRL_IDLE || ready !== 1'b1) begin n_err++; $display("FAIL mid_after cyc=%0d got=%b/%b exp=%b/1", c, sramCtrl, ready, CTRL_IDLE); end
      @(posedge clk); #1;
    end
    exp_res = {ref_rd(1), ref_rd(0)};
    run_access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, DONE_CYC + 1, 1'b0);
    n_vec++; if (obs_ready[DONE_CYC] !== 1'b1 || obs_ready[DONE_CYC - 1] !== 1'b0) begin n_err++; $display("FAIL mid_relat got=%b%b exp=01", obs_ready[DONE_CYC - 1], obs_ready[DONE_CYC]); end
    n_vec++; if (obs_res[DONE_CYC] !== exp_res) begin n_err++; $display("FAIL mid_reread got=%h exp=%h", obs_res[DONE_CYC], exp_res); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; model_result = 32'd0;
    rst = 1'b1; probe_en = 1'b0; probe_val = 16'h0;
    wbe_exe = 1'b0; memRead = 1'b0; memWrite = 1'b0; address = '0; data = '0;
    wbe_z = 1'b0; memRead_z = 1'b0; memWrite_z = 1'b0; address_z = '0; data_z = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_write_deadbeef();
    test_read_back();
    test_wait0();
    test_addr_window();
    test_hold_request();
    test_random_rw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_param.md
MEM_STAGE_PARAM -- requirements
Module: mem_stage_param

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning pipeline data word width in bits.
REQ-002 The block SHALL have parameter SRAM_DW, default 16, meaning SRAM data bus width; WORD_W SHALL be an integer multiple of SRAM_DW, with BEATS = WORD_W/SRAM_DW.
REQ-003 The block SHALL have parameter SRAM_AW, default 18, meaning SRAM address width.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2 (range 0..15), meaning extra cycles held per SRAM beat.
REQ-005 The block SHALL have parameter BASE_ADDR, default 1024, meaning the byte address mapped to SRAM word 0.
REQ-006 Clocking SHALL be one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-007 Port clk SHALL be an input, 1 bit, the system clock.
REQ-008 Port rst SHALL be an input, 1 bit, the asynchronous active-high reset.
REQ-009 Port writeBackEn_EXE_Reg SHALL be an input, 1 bit, the write-back enable from the EXE/MEM register.
REQ-010 Port memRead SHALL be an input, 1 bit, the load request.
REQ-011 Port memWrite SHALL be an input, 1 bit, the store request.
REQ-012 Port address SHALL be an input, WORD_W bits, the byte address.
REQ-013 Port data SHALL be an input, WORD_W bits, the store data.
REQ-014 Port sramData SHALL be an inout, SRAM_DW bits, the SRAM data bus.
REQ-015 Port sramAddress SHALL be an output, SRAM_AW bits, the SRAM address.
REQ-016 Port sramCtrl SHALL be an output, 5 bits, active-low SRAM controls: [4] WE_N, [3] UB_N, [2] LB_N, [1] CE_N, [0] OE_N.
REQ-017 Port memResult SHALL be an output, WORD_W bits, the assembled load data.
REQ-018 Port writeBackEn SHALL be an output, 1 bit, the gated write-back enable.
REQ-019 Port ready SHALL be an output, 1 bit, high when the stage may advance (low means freeze the pipeline).
REQ-020 Port addrError SHALL be an output, 1 bit, high when a requested address lies outside the SRAM window.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and DONE; it SHALL go IDLE->ACCESS on a valid request, ACCESS->DONE after the last beat, and DONE->IDLE unconditionally.
REQ-022 When memRead and memWrite are both high, the request SHALL be treated as a write.
REQ-023 Word index SHALL be (address - BASE_ADDR) >> log2(WORD_W/8), and beat b SHALL drive sramAddress = word index*BEATS + b, truncated to SRAM_AW bits.
REQ-024 Beats SHALL run b = 0..BEATS-1, with beat 0 carrying data bits [SRAM_DW-1:0] (low part first).
REQ-025 Each beat SHALL hold address, controls and data stable for WAIT_CYCLES+1 cycles, counted by a beat counter and a wait counter.
REQ-026 During a write in ACCESS, CE_N, UB_N, LB_N and WE_N SHALL be 0 and OE_N SHALL be 1, with sramData driven with the beat slice.
REQ-027 During a read in ACCESS, CE_N, UB_N, LB_N and OE_N SHALL be 0, WE_N SHALL be 1, and sramData SHALL be released to Z.
REQ-028 On a read, sramData SHALL be captured into the beat slice of memResult at the last cycle of each beat.
REQ-029 In IDLE and DONE, sramCtrl SHALL be 5'b11111 and sramData SHALL be Z.
REQ-030 ready SHALL be combinational: 1 in IDLE with no request, 0 in IDLE with a valid request, 0 in ACCESS, and 1 in DONE.
REQ-031 Latency SHALL be: request seen in IDLE at cycle 0, ready=1 at cycle BEATS*(WAIT_CYCLES+1)+1 (cycle 7 at defaults).
REQ-032 The DONE->IDLE transition SHALL prevent a held request from re-triggering the same access; a request present in the following IDLE cycle SHALL start a new access.
REQ-033 memResult SHALL update only on read beats and SHALL hold its value through writes and IDLE.
REQ-034 writeBackEn SHALL equal writeBackEn_EXE_Reg when ready=1, and 0 otherwise.
REQ-035 A request with address < BASE_ADDR, or with word index >= 2^SRAM_AW/BEATS, SHALL assert addrError combinationally, stay in IDLE with ready=1, and start no SRAM cycle.
REQ-036 Request inputs SHALL be sampled only in IDLE; changes to them during ACCESS SHALL be ignored, with data and address latched at the transition to ACCESS.

Reset
REQ-037 While rst=1, the FSM SHALL be in IDLE, counters SHALL be 0, memResult SHALL be 0, sramCtrl SHALL be 5'b11111, sramAddress SHALL be 0, sramData SHALL be Z, and ready SHALL be 1 when there is no request.
REQ-038 A reset asserted mid-ACCESS SHALL abort immediately (asynchronously), with no partial beat completed after reset is released.

Verification
REQ-039 A bench SHALL cover: write address=1024, data=0xDEADBEEF (defaults) -> sramAddress 0 then 1, sramData 0xBEEF then 0xDEAD, WE_N low 3 cycles per beat, ready high at cycle 7.
REQ-040 A bench SHALL cover: read address=1024 after that write -> memResult=0xDEADBEEF at DONE, writeBackEn equal to writeBackEn_EXE_Reg only at cycle 7.
REQ-041 A bench SHALL cover: WAIT_CYCLES=0, read address=1032 -> sramAddress 4 then 5, ready high at cycle 3.
REQ-042 A bench SHALL cover: address=1020 -> addrError=1, ready=1, sramCtrl=5'b11111 throughout.
REQ-043 A bench SHALL cover: memRead held high across DONE -> exactly one access per DONE, with a second access starting only in the next IDLE cycle.
REQ-044 A bench SHALL cover: rst pulsed during beat 1 of a write -> sramCtrl=5'b11111 and sramData=Z in the same cycle, state IDLE, memResult=0.
